// File: rtl/loop_uhat_sparse_mac_pipe.sv
// ----------------------------------------------------------------------------
// loop_uhat_sparse_mac_pipe: pipelined signed/unsigned multiplier; sums sparse rows when LOOP_UHAT_SPARSE_MAC_ACC_EN is defined
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module loop_uhat_sparse_mac_pipe #(
  parameter int DIN0_WIDTH = 50,
  parameter int DIN1_WIDTH = 50,
  parameter int DOUT_WIDTH = 100,
  parameter int NUM_STAGE  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  is_signed,
  input  logic                  in_last,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  out_valid
);

  localparam int MUL_STAGES = NUM_STAGE - 2;
  localparam int PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH + 2;

  // Stage 1: input capture
  logic [DIN0_WIDTH-1:0] a_q, a_d;
  logic [DIN1_WIDTH-1:0] b_q, b_d;
  logic                  sgn_q, sgn_d;
  logic                  vld1_q, vld1_d;

  // Multiply pipeline: the product is formed in the first slot, the rest are retiming slots
  logic [MUL_STAGES-1:0][DOUT_WIDTH-1:0] prod_q, prod_d;
  logic [MUL_STAGES-1:0]                 pvld_q, pvld_d;

  logic signed [DIN0_WIDTH:0]   a_ext;
  logic signed [DIN1_WIDTH:0]   b_ext;
  logic signed [PROD_WIDTH-1:0] prod_full;
  logic [DOUT_WIDTH-1:0]        prod_ext;

  logic [DOUT_WIDTH-1:0] dout_q, dout_d;
  logic                  out_valid_q, out_valid_d;

`ifdef LOOP_UHAT_SPARSE_MAC_ACC_EN
  logic                  last1_q, last1_d;
  logic [MUL_STAGES-1:0] plast_q, plast_d;
  logic [DOUT_WIDTH-1:0] acc_q, acc_d;
  logic                  row_open_q, row_open_d;
  logic [DOUT_WIDTH-1:0] row_sum;
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
`endif

  always_comb begin
    a_d    = din0;
    b_d    = din1;
    sgn_d  = is_signed;
    vld1_d = in_valid;
`ifdef LOOP_UHAT_SPARSE_MAC_ACC_EN
    last1_d = in_last;
`endif
  end

  // One extra bit per operand lets a single signed multiplier serve both modes
  always_comb begin
    a_ext     = {sgn_q & a_q[DIN0_WIDTH-1], a_q};
    b_ext     = {sgn_q & b_q[DIN1_WIDTH-1], b_q};
    prod_full = a_ext * b_ext;
    prod_ext  = DOUT_WIDTH'(prod_full);
  end

  always_comb begin
    prod_d    = prod_q;
    pvld_d    = pvld_q;
    prod_d[0] = prod_ext;
    pvld_d[0] = vld1_q;
    for (int i = 1; i < MUL_STAGES; i++) begin
      prod_d[i] = prod_q[i-1];
      pvld_d[i] = pvld_q[i-1];
    end
  end

`ifdef LOOP_UHAT_SPARSE_MAC_ACC_EN
  always_comb begin
    plast_d    = plast_q;
    plast_d[0] = last1_q;
    for (int i = 1; i < MUL_STAGES; i++) begin
      plast_d[i] = plast_q[i-1];
    end
  end

  // A fresh row ignores whatever acc still holds from the previous one
  always_comb begin
    dout_d      = dout_q;
    out_valid_d = 1'b0;
    acc_d       = acc_q;
    row_open_d  = row_open_q;
    row_sum     = (row_open_q ? acc_q : '0) + prod_q[MUL_STAGES-1];
    if (pvld_q[MUL_STAGES-1]) begin
      if (plast_q[MUL_STAGES-1]) begin
        dout_d      = row_sum;
        out_valid_d = 1'b1;
        row_open_d  = 1'b0;
      end else begin
        acc_d      = row_sum;
        row_open_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last1_q    <= 1'b0;
      plast_q    <= '0;
      acc_q      <= '0;
      row_open_q <= 1'b0;
    end else if (ce) begin
      last1_q    <= last1_d;
      plast_q    <= plast_d;
      acc_q      <= acc_d;
      row_open_q <= row_open_d;
    end
  end
`else
  always_comb begin
    dout_d      = dout_q;
    out_valid_d = pvld_q[MUL_STAGES-1];
    if (pvld_q[MUL_STAGES-1]) begin
      dout_d = prod_q[MUL_STAGES-1];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q         <= '0;
      b_q         <= '0;
      sgn_q       <= 1'b0;
      vld1_q      <= 1'b0;
      prod_q      <= '0;
      pvld_q      <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
    end else if (ce) begin
      a_q         <= a_d;
      b_q         <= b_d;
      sgn_q       <= sgn_d;
      vld1_q      <= vld1_d;
      prod_q      <= prod_d;
      pvld_q      <= pvld_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign dout      = dout_q;
  assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_loop_uhat_sparse_mac_pipe.sv
// ----------------------------------------------------------------------------
// tb_loop_uhat_sparse_mac_pipe: directed bench for loop_uhat_sparse_mac_pipe (8x8 -> 20 bits, 5 stages)
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_loop_uhat_sparse_mac_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        in_valid;
  logic [7:0]  din0;
  logic [7:0]  din1;
  logic        is_signed;
  logic        in_last;
  logic [19:0] dout;
  logic        out_valid;

  int err_cnt = 0;
  int chk_cnt = 0;
  int cyc     = 0;
  int got_q[$];
  int got_cyc[$];
  int exp_q[$];

  loop_uhat_sparse_mac_pipe #(
    .DIN0_WIDTH(8),
    .DIN1_WIDTH(8),
    .DOUT_WIDTH(20),
    .NUM_STAGE (5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .in_valid (in_valid),
    .din0     (din0),
    .din1     (din1),
    .is_signed(is_signed),
    .in_last  (in_last),
    .dout     (dout),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer: takes a result on each edge where ce && out_valid
  always @(negedge clk) begin
    if (ce && out_valid) begin
      got_q.push_back(int'(dout));
      got_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s, input logic l);
    din0      = a;
    din1      = b;
    is_signed = s;
    in_last   = l;
    in_valid  = 1'b1;
    step();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) step();
  endtask

  task automatic check_results(input string tag);
    check($sformatf("%s_count", tag), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check($sformatf("%s[%0d]", tag, i), got_q[i], exp_q[i]);
    end
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int cyc0;
    int n;
    reset = 1'b1; ce = 1'b1; in_valid = 1'b0; din0 = '0; din1 = '0;
    is_signed = 1'b0; in_last = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    check("rst_dout", dout, 0);
    check("rst_ov", out_valid, 0);
    step();

    // 1: unsigned single-term row, latency and one-cycle pulse
    send(8'd255, 8'd255, 1'b0, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("t1_early%0d", i), out_valid, 0);
    end
    step();
    check("t1_ov", out_valid, 1);
    check("t1_dout", dout, 65025);
    step();
    check("t1_pulse", out_valid, 0);
    check("t1_hold", dout, 65025);
    idle(4);
    exp_q.push_back(65025);
    check_results("t1");

    // 2: signed single-term row
    send(8'h80, 8'h7F, 1'b1, 1'b1);
    idle(8);
    exp_q.push_back(32'h000FC080);
    check_results("t2");

    // 3: back-to-back rows
    send(8'd3, 8'd4, 1'b0, 1'b0);
    send(8'd5, 8'd6, 1'b0, 1'b0);
    send(8'd1, 8'd1, 1'b0, 1'b0);
    send(8'd10, 8'd10, 1'b0, 1'b1);
    send(8'd2, 8'd2, 1'b0, 1'b1);
    idle(8);
`ifdef LOOP_UHAT_SPARSE_MAC_ACC_EN
    exp_q.push_back(143); exp_q.push_back(4);
`else
    exp_q.push_back(12); exp_q.push_back(30); exp_q.push_back(1);
    exp_q.push_back(100); exp_q.push_back(4);
`endif
    check_results("t3");

    // 4: three-cycle ce stall after the second sample
    send(8'd3, 8'd4, 1'b0, 1'b0);
    cyc0 = cyc;
    send(8'd5, 8'd6, 1'b0, 1'b0);
    in_valid = 1'b0;
    ce = 1'b0;
    repeat (3) step();
    ce = 1'b1;
    send(8'd1, 8'd1, 1'b0, 1'b0);
    send(8'd10, 8'd10, 1'b0, 1'b1);
    idle(8);
    if (got_cyc.size() > 0) check("t4_when", got_cyc[got_cyc.size()-1], cyc0 + 10);
`ifdef LOOP_UHAT_SPARSE_MAC_ACC_EN
    exp_q.push_back(143);
`else
    exp_q.push_back(12); exp_q.push_back(30); exp_q.push_back(1); exp_q.push_back(100);
`endif
    check_results("t4");

    // 4b: stall while a result is pending; it must stay up and be taken once
    send(8'd2, 8'd2, 1'b0, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      step();
      n++;
    end
    check("t4b_seen", out_valid, 1);
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t4b_hold_ov%0d", i), out_valid, 1);
      check($sformatf("t4b_hold_dout%0d", i), dout, 4);
    end
    ce = 1'b1;
    idle(6);
    exp_q.push_back(4);
    check_results("t4b");

    // 5: reset in the middle of a row
    send(8'd9, 8'd9, 1'b0, 1'b0);
    send(8'd9, 8'd9, 1'b0, 1'b0);
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    check("t5_rst_dout", dout, 0);
    check("t5_rst_ov", out_valid, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("t5_post_dout%0d", i), dout, 0);
      check($sformatf("t5_post_ov%0d", i), out_valid, 0);
    end
    send(8'd2, 8'd2, 1'b0, 1'b1);
    idle(8);
    exp_q.push_back(4);
    check_results("t5");

    // 6: accumulator wrap-around
    for (int i = 0; i < 20; i++) send(8'd255, 8'd255, 1'b0, (i == 19));
    idle(8);
`ifdef LOOP_UHAT_SPARSE_MAC_ACC_EN
    exp_q.push_back(251924);
`else
    for (int i = 0; i < 20; i++) exp_q.push_back(65025);
`endif
    check_results("t6");

    // 7: signed and unsigned terms mixed in one row
    send(8'hFF, 8'd2, 1'b1, 1'b0);
    send(8'hFF, 8'd2, 1'b0, 1'b1);
    idle(8);
`ifdef LOOP_UHAT_SPARSE_MAC_ACC_EN
    exp_q.push_back(508);
`else
    exp_q.push_back(1048574); exp_q.push_back(510);
`endif
    check_results("t7");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

`default_nettype wire
